// File: rtl/dir_pkg.sv
// rtl/dir_pkg.sv - shared constants and types for the direction-frame scheduler
package dir_pkg;

   localparam int FRAME_BYTES = 240;
   localparam int PAIRS       = 120;

   typedef enum logic [2:0] {
      DIR_H    = 3'b001,
      DIR_V    = 3'b010,
      DIR_ANTI = 3'b011,
      DIR_DIAG = 3'b100
   } dir_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting just after the last owner
module rr_arbiter
   import dir_pkg::*;
#(
   parameter int N_SRC = 2
) (
   input  logic [N_SRC-1:0] req,
   input  logic [1:0]       last,
   output logic [N_SRC-1:0] grant,
   output logic [1:0]       idx,
   output logic             found
);

   // Offset i walks the ring from last+1; the first requester met wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 1; i <= N_SRC; i++) begin
         for (int j = 0; j < N_SRC; j++) begin
            if (!found && req[j] && (j == (int'(last) + i) % N_SRC)) begin
               found    = 1'b1;
               grant[j] = 1'b1;
               idx      = 2'(j);
            end
         end
      end
   end

endmodule

// File: rtl/dir_frame_sched.sv
// rtl/dir_frame_sched.sv - frame scheduler sharing one direction detector among byte sources
module dir_frame_sched
   import dir_pkg::*;
#(
   parameter int N_SRC   = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [N_SRC-1:0]     i_req,
   input  logic [N_SRC-1:0]     i_valid,
   input  logic [8*N_SRC-1:0]   i_data,
   output logic [N_SRC-1:0]     o_ready,
   output logic [N_SRC-1:0]     o_grant,
   output logic                 o_det_enb,
   output logic [7:0]           o_det_data,
   output logic                 o_det_rst,
   input  logic                 i_det_valid,
   input  logic [2:0]           i_det_dir,
   output logic                 o_res_valid,
   output logic [2:0]           o_res_dir,
   output logic [1:0]           o_res_src,
   output logic [6:0]           o_res_idx,
   output logic                 o_res_last,
   output logic                 o_busy,
   output logic                 o_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   sched_state_t     state, state_nx;
   logic [N_SRC-1:0] grant_q;
   logic [1:0]       owner;
   logic [1:0]       last_idx;
   logic [7:0]       byte_cnt;
   logic [6:0]       res_cnt;
   logic [WD_W-1:0]  wd_cnt;

   logic [N_SRC-1:0] arb_grant;
   logic [1:0]       arb_idx;
   logic             arb_found;
   logic             hs, res_ok, progress, wd_expire, frame_sent, res_done;
   logic [7:0]       sel_data;

   rr_arbiter #(.N_SRC(N_SRC)) u_arb (
      .req   (i_req),
      .last  (last_idx),
      .grant (arb_grant),
      .idx   (arb_idx),
      .found (arb_found)
   );

   assign o_ready    = (state == S_SEND) ? grant_q : '0;
   assign o_grant    = grant_q;
   assign o_busy     = (state != S_IDLE);
   assign hs         = |(i_valid & o_ready);
   assign res_ok     = (state == S_WAIT) && i_det_valid;
   assign progress   = hs || res_ok;
   assign frame_sent = hs && (byte_cnt == 8'(FRAME_BYTES - 1));
   assign res_done   = res_ok && (res_cnt == 7'(PAIRS - 1));
   // Progress in the same cycle always beats an expiring watchdog.
   assign wd_expire  = (state != S_IDLE) && !progress && (wd_cnt == WD_W'(TIMEOUT - 1));

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (owner == 2'(k)) sel_data = i_data[8*k +: 8];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (arb_found) state_nx = S_SEND;
         S_SEND:  if (frame_sent) state_nx = S_WAIT;
                  else if (wd_expire) state_nx = S_IDLE;
         S_WAIT:  if (res_done || wd_expire) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         grant_q     <= '0;
         owner       <= '0;
         last_idx    <= 2'(N_SRC - 1);
         byte_cnt    <= '0;
         res_cnt     <= '0;
         wd_cnt      <= '0;
         o_det_enb   <= 1'b0;
         o_det_data  <= '0;
         o_det_rst   <= 1'b0;
         o_res_valid <= 1'b0;
         o_res_dir   <= '0;
         o_res_src   <= '0;
         o_res_idx   <= '0;
         o_res_last  <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         o_det_enb   <= hs;
         o_res_valid <= res_ok;
         o_res_last  <= res_done;
         o_err       <= wd_expire;
         o_det_rst   <= wd_expire;
         if (hs) o_det_data <= sel_data;
         if (res_ok) begin
            o_res_dir <= i_det_dir;
            o_res_src <= owner;
            o_res_idx <= res_cnt;
         end

         if (state == S_IDLE || progress) wd_cnt <= '0;
         else if (!wd_expire)              wd_cnt <= wd_cnt + 1'b1;

         unique case (state)
            S_IDLE: if (arb_found) begin
               grant_q  <= arb_grant;
               owner    <= arb_idx;
               byte_cnt <= '0;
               res_cnt  <= '0;
            end
            S_SEND: if (hs) byte_cnt <= byte_cnt + 8'd1;
            S_WAIT: if (res_ok) res_cnt <= res_cnt + 7'd1;
            default: ;
         endcase

         // Both a completed frame and an abort hand priority past the owner.
         if (res_done || wd_expire) begin
            grant_q  <= '0;
            last_idx <= owner;
         end
      end
   end

endmodule

// File: tb/tb_dir_frame_sched.sv
// tb/tb_dir_frame_sched.sv - scoreboard bench for dir_frame_sched with a stub detector
module tb_dir_frame_sched;

   localparam int N_SRC   = 2;
   localparam int TIMEOUT = 15;

   logic               clk = 1'b0;
   logic               rst;
   logic [N_SRC-1:0]   i_req, i_valid;
   logic [8*N_SRC-1:0] i_data;
   logic [N_SRC-1:0]   o_ready, o_grant;
   logic               o_det_enb, o_det_rst;
   logic [7:0]         o_det_data;
   logic               i_det_valid;
   logic [2:0]         i_det_dir;
   logic               o_res_valid, o_res_last, o_busy, o_err;
   logic [2:0]         o_res_dir;
   logic [1:0]         o_res_src;
   logic [6:0]         o_res_idx;

   dir_frame_sched #(.N_SRC(N_SRC), .TIMEOUT(TIMEOUT)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (i_req),
      .i_valid     (i_valid),
      .i_data      (i_data),
      .o_ready     (o_ready),
      .o_grant     (o_grant),
      .o_det_enb   (o_det_enb),
      .o_det_data  (o_det_data),
      .o_det_rst   (o_det_rst),
      .i_det_valid (i_det_valid),
      .i_det_dir   (i_det_dir),
      .o_res_valid (o_res_valid),
      .o_res_dir   (o_res_dir),
      .o_res_src   (o_res_src),
      .o_res_idx   (o_res_idx),
      .o_res_last  (o_res_last),
      .o_busy      (o_busy),
      .o_err       (o_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]       bq[$];
   logic [12:0]      rq[$];
   logic [N_SRC-1:0] gq[$];
   int               src_hs[N_SRC];
   int               cyc = 0;
   int               det_cnt, res_cnt, last_cnt, err_cnt, frame_det;
   int               first_det_cyc, last_det_cyc, last_res_cyc, err_cyc, first_res_idx;
   int               stub_n = 120, stub_left = 0, stub_idx = 0;
   bit               stub_phase;
   logic [1:0]       exp_src = 2'd0;
   logic [N_SRC-1:0] prev_grant = '0;
   logic             force_dv = 1'b0;

   function automatic logic [7:0] src_byte(int s, int n);
      return 8'(s * 97 + n * 13 + 5);
   endfunction

   function automatic logic [2:0] det_code(int idx);
      return 3'(idx * 5 + 3);
   endfunction

   // One clock: drive sources and stub for the next edge, then score what the DUT produced.
   task automatic tick();
      logic             fire;
      logic [7:0]       e8;
      logic [12:0]      e13;
      logic [N_SRC-1:0] eg;
      for (int s = 0; s < N_SRC; s++) begin
         i_data[8*s +: 8] = src_byte(s, src_hs[s]);
         if (i_valid[s] && o_ready[s]) begin
            bq.push_back(src_byte(s, src_hs[s]));
            src_hs[s]++;
         end
      end
      fire = 1'b0;
      if (stub_left > 0) begin
         if (stub_phase) begin
            fire      = 1'b1;
            i_det_dir = det_code(stub_idx);
            rq.push_back({exp_src, 7'(stub_idx), det_code(stub_idx), stub_idx == 119});
            stub_idx++;
            stub_left--;
         end
         stub_phase = ~stub_phase;
      end
      i_det_valid = fire | force_dv;
      @(negedge clk);
      cyc++;

      if (o_det_enb) begin
         n_tests++;
         if (bq.size() == 0) begin
            n_fail++;
            $display("FAIL det_byte: got unexpected byte %h, expected none", o_det_data);
         end else begin
            e8 = bq.pop_front();
            if (o_det_data !== e8) begin
               n_fail++;
               $display("FAIL det_byte: got %h expected %h", o_det_data, e8);
            end
         end
         if (det_cnt == 0) first_det_cyc = cyc;
         last_det_cyc = cyc;
         det_cnt++;
         frame_det++;
         if (frame_det == 240) begin
            frame_det  = 0;
            stub_left  = stub_n;
            stub_idx   = 0;
            stub_phase = 1'b1;
         end
      end

      if (o_res_valid) begin
         n_tests++;
         if (rq.size() == 0) begin
            n_fail++;
            $display("FAIL result: got unexpected src=%0d idx=%0d, expected none", o_res_src, o_res_idx);
         end else begin
            e13 = rq.pop_front();
            if ({o_res_src, o_res_idx, o_res_dir, o_res_last} !== e13) begin
               n_fail++;
               $display("FAIL result: got src=%0d idx=%0d dir=%0d last=%0b expected src=%0d idx=%0d dir=%0d last=%0b",
                        o_res_src, o_res_idx, o_res_dir, o_res_last, e13[12:11], e13[10:4], e13[3:1], e13[0]);
            end
         end
         if (res_cnt == 0) first_res_idx = int'(o_res_idx);
         res_cnt++;
         last_res_cyc = cyc;
         if (o_res_last) last_cnt++;
      end

      if (o_err) begin
         err_cnt++;
         err_cyc   = cyc;
         frame_det = 0;
      end

      if (o_grant != prev_grant && o_grant != '0) begin
         n_tests++;
         if (gq.size() == 0) begin
            n_fail++;
            $display("FAIL grant_order: got %b expected no grant", o_grant);
         end else begin
            eg      = gq.pop_front();
            exp_src = eg[1] ? 2'd1 : 2'd0;
            if (o_grant !== eg) begin
               n_fail++;
               $display("FAIL grant_order: got %b expected %b", o_grant, eg);
            end
         end
      end
      prev_grant = o_grant;
   endtask

   task automatic apply_reset();
      rst         = 1'b1;
      i_req       = '0;
      i_valid     = '0;
      i_data      = '0;
      force_dv    = 1'b0;
      i_det_valid = 1'b0;
      i_det_dir   = '0;
      repeat (3) @(negedge clk);
      bq.delete();
      rq.delete();
      gq.delete();
      for (int s = 0; s < N_SRC; s++) src_hs[s] = 0;
      det_cnt = 0; res_cnt = 0; last_cnt = 0; err_cnt = 0; frame_det = 0;
      stub_left = 0; stub_n = 120; prev_grant = '0;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++;
      if ({o_grant, o_ready, o_busy, o_det_enb, o_det_rst, o_res_valid, o_res_last, o_err,
           o_det_data, o_res_dir, o_res_src, o_res_idx} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got grant=%b ready=%b busy=%b enb=%b err=%b expected all zero",
                  o_grant, o_ready, o_busy, o_det_enb, o_err);
      end
      force_dv = 1'b1;
      tick();
      force_dv = 1'b0;
      tick();
      n_tests++;
      if (res_cnt !== 0 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_det_valid: got results=%0d busy=%b expected 0 and 0", res_cnt, o_busy);
      end
   endtask

   task automatic test_single_src();
      apply_reset();
      gq.push_back(2'b01);
      i_req   = 2'b01;
      i_valid = 2'b01;
      tick();
      n_tests++;
      if (o_grant !== 2'b01 || o_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL grant_latency: got grant=%b ready=%b expected 01 and 01", o_grant, o_ready);
      end
      i_req = 2'b00;
      for (int c = 0; c < 1000 && last_cnt == 0; c++) begin
         tick();
         if (o_det_enb && det_cnt == 240) begin
            n_tests++;
            if (o_ready !== '0) begin
               n_fail++;
               $display("FAIL ready_drop: got %b expected 00", o_ready);
            end
         end
      end
      n_tests++;
      if (last_cnt !== 1 || det_cnt !== 240 || res_cnt !== 120) begin
         n_fail++;
         $display("FAIL single_counts: got last=%0d bytes=%0d results=%0d expected 1 240 120", last_cnt, det_cnt, res_cnt);
      end
      n_tests++;
      if (last_det_cyc - first_det_cyc !== 239 || first_res_idx !== 0) begin
         n_fail++;
         $display("FAIL single_span: got span=%0d first_idx=%0d expected 239 0", last_det_cyc - first_det_cyc, first_res_idx);
      end
      tick();
      n_tests++;
      if (o_busy !== 1'b0 || o_grant !== '0) begin
         n_fail++;
         $display("FAIL single_idle: got busy=%b grant=%b expected 0 00", o_busy, o_grant);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10);
      i_req   = 2'b11;
      i_valid = 2'b11;
      for (int c = 0; c < 3000 && last_cnt < 4; c++) begin
         tick();
         if (last_cnt == 4) i_req = 2'b00;
      end
      tick();
      n_tests++;
      if (last_cnt !== 4 || res_cnt !== 480 || det_cnt !== 960 || gq.size() !== 0) begin
         n_fail++;
         $display("FAIL back_to_back: got last=%0d results=%0d bytes=%0d grants_left=%0d expected 4 480 960 0",
                  last_cnt, res_cnt, det_cnt, gq.size());
      end
   endtask

   task automatic test_gap();
      int gap_left = -1;
      int prev_det = -1;
      int max_diff = 0;
      apply_reset();
      gq.push_back(2'b10);
      i_req   = 2'b10;
      i_valid = 2'b10;
      for (int c = 0; c < 1500 && last_cnt == 0; c++) begin
         tick();
         if (o_det_enb) begin
            if (prev_det >= 0 && cyc - prev_det > max_diff) max_diff = cyc - prev_det;
            prev_det = cyc;
         end
         if (src_hs[1] == 50 && gap_left < 0) begin
            i_valid[1] = 1'b0;
            gap_left   = 10;
         end else if (gap_left > 0) begin
            gap_left--;
            if (gap_left == 0) i_valid[1] = 1'b1;
         end
         if (o_grant == 2'b10) i_req = 2'b00;
      end
      n_tests++;
      if (err_cnt !== 0 || det_cnt !== 240 || last_cnt !== 1) begin
         n_fail++;
         $display("FAIL gap_counts: got err=%0d bytes=%0d last=%0d expected 0 240 1", err_cnt, det_cnt, last_cnt);
      end
      n_tests++;
      if (last_det_cyc - first_det_cyc !== 249 || max_diff !== 11) begin
         n_fail++;
         $display("FAIL gap_shape: got span=%0d max_step=%0d expected 249 11", last_det_cyc - first_det_cyc, max_diff);
      end
   endtask

   task automatic test_stall();
      apply_reset();
      gq.push_back(2'b01);
      gq.push_back(2'b10);
      i_req   = 2'b11;
      i_valid = 2'b01;
      for (int c = 0; c < 600 && err_cnt == 0; c++) begin
         tick();
         if (src_hs[0] == 100 && i_valid[0]) i_valid[0] = 1'b0;
      end
      n_tests++;
      if (err_cnt !== 1 || err_cyc - last_det_cyc !== TIMEOUT || det_cnt !== 100) begin
         n_fail++;
         $display("FAIL stall_timeout: got errs=%0d delay=%0d bytes=%0d expected 1 %0d 100",
                  err_cnt, err_cyc - last_det_cyc, det_cnt, TIMEOUT);
      end
      n_tests++;
      if (o_det_rst !== 1'b1 || o_grant !== '0 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_abort: got det_rst=%b grant=%b busy=%b expected 1 00 0", o_det_rst, o_grant, o_busy);
      end
      tick();
      n_tests++;
      if (o_grant !== 2'b10 || o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_regrant: got grant=%b err=%b expected 10 0", o_grant, o_err);
      end
      i_req   = 2'b00;
      i_valid = 2'b10;
      for (int c = 0; c < 1000 && last_cnt == 0; c++) tick();
      n_tests++;
      if (det_cnt !== 340 || res_cnt !== 120 || last_cnt !== 1) begin
         n_fail++;
         $display("FAIL stall_recover: got bytes=%0d results=%0d last=%0d expected 340 120 1", det_cnt, res_cnt, last_cnt);
      end
   endtask

   task automatic test_short_det();
      apply_reset();
      stub_n = 50;
      gq.push_back(2'b01);
      i_req   = 2'b01;
      i_valid = 2'b01;
      tick();
      i_req = 2'b00;
      for (int c = 0; c < 1000 && err_cnt == 0; c++) tick();
      n_tests++;
      if (res_cnt !== 50 || last_cnt !== 0 || err_cnt !== 1) begin
         n_fail++;
         $display("FAIL short_det: got results=%0d last=%0d errs=%0d expected 50 0 1", res_cnt, last_cnt, err_cnt);
      end
      n_tests++;
      if (err_cyc - last_res_cyc !== TIMEOUT || o_busy !== 1'b0 || o_det_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL short_det_abort: got delay=%0d busy=%b det_rst=%b expected %0d 0 1",
                  err_cyc - last_res_cyc, o_busy, o_det_rst, TIMEOUT);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      gq.push_back(2'b01);
      i_req   = 2'b01;
      i_valid = 2'b01;
      for (int c = 0; c < 400 && src_hs[0] < 120; c++) tick();
      rst = 1'b1;
      #1;
      n_tests++;
      if ({o_grant, o_ready, o_busy, o_det_enb, o_det_rst, o_res_valid, o_res_last, o_err,
           o_det_data, o_res_dir, o_res_src, o_res_idx} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: got grant=%b ready=%b busy=%b enb=%b det_rst=%b expected all zero",
                  o_grant, o_ready, o_busy, o_det_enb, o_det_rst);
      end
      apply_reset();
      gq.push_back(2'b01);
      i_req   = 2'b01;
      i_valid = 2'b01;
      tick();
      i_req = 2'b00;
      for (int c = 0; c < 1000 && last_cnt == 0; c++) tick();
      n_tests++;
      if (first_res_idx !== 0 || res_cnt !== 120 || det_cnt !== 240) begin
         n_fail++;
         $display("FAIL reset_restart: got first_idx=%0d results=%0d bytes=%0d expected 0 120 240",
                  first_res_idx, res_cnt, det_cnt);
      end
   endtask

   initial begin
      rst         = 1'b1;
      i_req       = '0;
      i_valid     = '0;
      i_data      = '0;
      i_det_valid = 1'b0;
      i_det_dir   = '0;
      test_reset();
      test_single_src();
      test_back_to_back();
      test_gap();
      test_stall();
      test_short_det();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dir_frame_sched.md
# dir_frame_sched

Frame-level scheduler that shares one direction-detector datapath among several byte-stream sources. It grants one source at a time using round-robin arbitration, and forwards exactly one 240-byte frame (120 signed vx/vy pairs) into the detector. It then collects the detector's 120 direction codes and re-emits them tagged with source ID and pair index. It sits between the sensor/ingest front-ends and the single detector instance, and guards against a stalled source or detector with a watchdog.

## Interface
Parameters:
- N_SRC, 2: number of requesting sources, 2..4.
- TIMEOUT, 1023: idle cycles tolerated in SEND or WAIT before abort.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req  in  N_SRC  per-source frame-pending request.
- i_valid  in  N_SRC  per-source byte valid.
- i_data  in  8*N_SRC  per-source signed byte, source k at bits [8k+7:8k].
- o_ready  out  N_SRC  per-source byte ready.
- o_grant  out  N_SRC  one-hot current owner, 0 when idle.
- o_det_enb  out  1  byte strobe to detector.
- o_det_data  out  8  byte to detector.
- o_det_rst  out  1  one-cycle synchronous reset pulse to detector.
- i_det_valid  in  1  detector result strobe.
- i_det_dir  in  3  detector direction code.
- o_res_valid  out  1  tagged result strobe.
- o_res_dir  out  3  direction code.
- o_res_src  out  2  source ID.
- o_res_idx  out  7  pair index, 0..119.
- o_res_last  out  1  set with result idx 119.
- o_busy  out  1  high when the state is not IDLE.
- o_err  out  1  one-cycle timeout pulse.

## Operation
- States: IDLE, SEND, WAIT.
- IDLE:
  - If any i_req is set, select the first requester after the last-granted index, wrapping around.
  - Load o_grant and clear the byte counter and watchdog, then go to SEND.
  - If no request is pending, stay in IDLE.
- SEND:
  - o_ready[k] = (state==SEND) && o_grant[k]. All other ready bits are 0.
  - A handshake is i_valid[g] && o_ready[g]. Each handshake registers o_det_data = i_data[g] and asserts o_det_enb for 1 cycle.
  - The byte counter runs 0..239. The handshake at count 239 moves the FSM to WAIT.
  - The value of i_req during SEND is ignored. Withdrawing it does not abort the frame.
- WAIT:
  - Each i_det_valid registers o_res_dir/src/idx and pulses o_res_valid. The result counter then increments.
  - The result at idx 119 also asserts o_res_last, updates the last-granted index, and moves the FSM to IDLE.
- i_det_valid outside WAIT is dropped and does not move any counter.
- Watchdog:
  - The watchdog counts cycles without progress. Progress is a handshake in SEND or a result in WAIT. Any progress clears the counter.
  - When the count reaches TIMEOUT, pulse o_err and o_det_rst, advance the last-granted index past the owner, clear o_grant, and go to IDLE.
  - The partial frame is discarded. Results already emitted stand.
- Arbitration is round-robin at frame granularity. A continuously requesting source cannot starve another one.
- Direction codes pass through unmodified.

## Timing
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - The last-granted index resets to N_SRC-1, so source 0 wins first.
- Reset mid-frame aborts immediately. No o_det_rst pulse is issued; the detector shares i_rst.
- Grant latency: from i_req seen in IDLE, o_grant and o_ready rise on the next cycle.
- Byte path: o_det_enb and o_det_data follow the handshake by 1 cycle. With i_valid held high, a frame takes 240 consecutive cycles.
- Result path: o_res_* follow i_det_valid by 1 cycle.
- o_ready drops on the cycle after the 240th handshake. There is no 241st acceptance.
- A new grant is possible on the cycle after o_res_last.
- If timeout and a handshake or result land in the same cycle, the progress wins and the watchdog clears.
- Counter widths: 8-bit byte counter, 7-bit result counter, watchdog of $clog2(TIMEOUT+1) bits.

## Structure
- Shared package dir_pkg holds:
  - FRAME_BYTES=240 and PAIRS=120.
  - dir_t enum: DIR_H=3'b001, DIR_V=3'b010, DIR_ANTI=3'b011, DIR_DIAG=3'b100.
  - sched_state_t enum {S_IDLE, S_SEND, S_WAIT}.
- Sub-module rr_arbiter, combinational, with inputs req, last index, and N_SRC. It outputs a one-hot grant plus an index.

## Test plan
- Source 0 only, i_valid high, with a stub detector returning 120 results at 2-cycle spacing. Expect exactly 240 o_det_enb pulses in 240 cycles and 120 o_res_valid with src=0 and idx 0..119. o_res_last is set only at idx 119.
- Both sources requesting continuously: grants alternate 0,1,0,1 over 4 frames. Each result burst carries the matching o_res_src.
- Source 1 drops i_valid for 10 cycles mid-frame with TIMEOUT=1023: no error, 240 bytes total, with a 10-cycle gap on o_det_enb.
- Source stalls at byte 100 with TIMEOUT=15. o_err and o_det_rst pulse 15 cycles after the last handshake, and o_grant returns to 0. The other requester is granted the next cycle.
- Stub detector returns only 50 results with TIMEOUT=15: 50 tagged results, then o_err. No o_res_last is seen, and the FSM is back in IDLE.
- Assert i_rst at byte 120: all outputs go to 0 at once. After release, source 0 is granted first and the frame restarts at idx 0.
